// File: rtl/led_pattern_if.sv
// led_pattern_if
//   Control and LED bundle between a top level and the LED pattern generator.
//   master: drives enable/mode and observes tick/led (top level or testbench).
//   slave : the pattern generator itself.
//   Signals:
//     enable  1 = run, 0 = freeze state and blank the LEDs
//     mode    pattern select (0 COUNT, 1 SCAN, 2 ROTATE, 3 BREATHE)
//     tick    combinational pattern-advance strobe
//     led     registered LED drive, 1 = on
interface led_pattern_if #(
    parameter int LED_WIDTH = 8
);
    logic                 enable;
    logic [1:0]           mode;
    logic                 tick;
    logic [LED_WIDTH-1:0] led;

    modport master (
        output enable,
        output mode,
        input  tick,
        input  led
    );

    modport slave (
        input  enable,
        input  mode,
        output tick,
        output led
    );
endinterface

// File: rtl/led_pattern.sv
// led_pattern
//   Multi-mode LED pattern generator. A power-of-two prescaler produces a
//   pattern-advance strobe every 2^PRESCALE_WIDTH enabled clocks; on each
//   strobe the state of the selected pattern steps once. The LED bank is
//   driven from a register that is reloaded every clock from the current
//   state.
//
//   Parameters:
//     LED_WIDTH       number of LEDs (>= 2)
//     PRESCALE_WIDTH  prescaler width (>= 1)
//     PWM_WIDTH       PWM counter / duty width for breathe mode (>= 1)
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    led_pattern_if slave: enable, mode in; tick, led out
//
//   mode_q        | meaning
//   --------------+-----------------------------------------------------
//   MODE_COUNT    | led shows a binary counter, +1 per tick
//   MODE_SCAN     | single lit LED bouncing end to end, endpoints once
//   MODE_ROTATE   | single lit LED rotating upward with wrap
//   MODE_BREATHE  | all LEDs PWM'd, duty ramps up to max then back to 0
module led_pattern #(
    parameter int LED_WIDTH      = 8,
    parameter int PRESCALE_WIDTH = 24,
    parameter int PWM_WIDTH      = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    led_pattern_if.slave bus
);

    localparam int POS_WIDTH = $clog2(LED_WIDTH);

    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);
    localparam logic [POS_WIDTH-1:0]      POS_ONE = POS_WIDTH'(1);
    localparam logic [POS_WIDTH-1:0]      POS_MAX = POS_WIDTH'(LED_WIDTH - 1);
    localparam logic [PWM_WIDTH-1:0]      PWM_ONE = PWM_WIDTH'(1);
    localparam logic [LED_WIDTH-1:0]      LED_ONE = LED_WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_ROTATE  = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PRESCALE_WIDTH-1:0] pre_q,  pre_d;
    mode_e                     mode_q, mode_d;
    logic [LED_WIDTH-1:0]      step_q, step_d;
    logic [POS_WIDTH-1:0]      pos_q,  pos_d;
    dir_e                      dir_q,  dir_d;
    logic [PWM_WIDTH-1:0]      duty_q, duty_d;
    logic [PWM_WIDTH-1:0]      pwm_q,  pwm_d;
    logic [LED_WIDTH-1:0]      led_q,  led_d;

    mode_e mode_in;
    logic  mode_chg;
    logic  tick;

    assign mode_in  = mode_e'(bus.mode);
    assign mode_chg = bus.enable && (mode_in != mode_q);
    // A pending mode change suppresses the strobe so the old pattern never
    // advances on the edge that switches modes.
    assign tick     = bus.enable && (pre_q == '1) && (mode_in == mode_q);

    assign bus.tick = tick;
    assign bus.led  = led_q;

    always_comb begin
        pre_d  = pre_q;
        mode_d = mode_q;
        step_d = step_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        duty_d = duty_q;
        pwm_d  = pwm_q;

        if (bus.enable) begin
            pre_d = pre_q + PRE_ONE;
            // The PWM counter free-runs across mode changes on purpose.
            pwm_d = pwm_q + PWM_ONE;

            if (mode_chg) begin
                mode_d = mode_in;
                pre_d  = '0;
                step_d = '0;
                pos_d  = '0;
                duty_d = '0;
                dir_d  = DIR_UP;
            end else if (tick) begin
                case (mode_q)
                    MODE_COUNT: begin
                        step_d = step_q + LED_ONE;
                    end
                    MODE_SCAN: begin
                        if (dir_q == DIR_UP) begin
                            if (pos_q == POS_MAX) begin
                                dir_d = DIR_DOWN;
                                pos_d = pos_q - POS_ONE;
                            end else begin
                                pos_d = pos_q + POS_ONE;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = DIR_UP;
                                pos_d = POS_ONE;
                            end else begin
                                pos_d = pos_q - POS_ONE;
                            end
                        end
                    end
                    MODE_ROTATE: begin
                        // Explicit wrap keeps non-power-of-two widths in range.
                        if (pos_q == POS_MAX) begin
                            pos_d = '0;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end
                    MODE_BREATHE: begin
                        if (dir_q == DIR_UP) begin
                            if (duty_q == '1) begin
                                dir_d  = DIR_DOWN;
                                duty_d = duty_q - PWM_ONE;
                            end else begin
                                duty_d = duty_q + PWM_ONE;
                            end
                        end else begin
                            if (duty_q == '0) begin
                                dir_d  = DIR_UP;
                                duty_d = PWM_ONE;
                            end else begin
                                duty_d = duty_q - PWM_ONE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // LED image is built from the state as it stands before this edge, so a
    // state change shows on the pins one clock after it is taken.
    always_comb begin
        led_d = '0;
        if (bus.enable) begin
            case (mode_q)
                MODE_COUNT:              led_d = step_q;
                MODE_SCAN, MODE_ROTATE:  led_d = LED_ONE << pos_q;
                MODE_BREATHE:            led_d = {LED_WIDTH{pwm_q < duty_q}};
                default:                 led_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            mode_q <= MODE_COUNT;
            step_q <= '0;
            pos_q  <= '0;
            dir_q  <= DIR_UP;
            duty_q <= '0;
            pwm_q  <= '0;
            led_q  <= '0;
        end else begin
            pre_q  <= pre_d;
            mode_q <= mode_d;
            step_q <= step_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
            led_q  <= led_d;
        end
    end

endmodule
